// File: rtl/toy_operand_unit_if.sv
// Decode/writeback-facing bus of the operand unit.
// The decode/writeback side uses master; the unit uses slave.
interface toy_operand_unit_if #(
    parameter int DW  = 32,
    parameter int AW  = 5,
    parameter int NRD = 2
);
    logic [NRD*AW-1:0] RA;
    logic [NRD*DW-1:0] RD;
    logic [NRD-1:0]    SRC_EN;
    logic              ISSUE_VALID;
    logic              ISSUE_WEN;
    logic [AW-1:0]     ISSUE_WA;
    logic              ISSUE_READY;
    logic              WEN;
    logic [AW-1:0]     WA;
    logic [DW-1:0]     DI;
    logic              KILL_VALID;
    logic [AW-1:0]     KILL_WA;
    logic              BUSY;
    logic              ERR;

    modport master (
        output RA, SRC_EN, ISSUE_VALID, ISSUE_WEN, ISSUE_WA, WEN, WA, DI, KILL_VALID, KILL_WA,
        input  RD, ISSUE_READY, BUSY, ERR
    );
    modport slave (
        input  RA, SRC_EN, ISSUE_VALID, ISSUE_WEN, ISSUE_WA, WEN, WA, DI, KILL_VALID, KILL_WA,
        output RD, ISSUE_READY, BUSY, ERR
    );
endinterface

// File: rtl/toy_operand_unit.sv
// Operand supply: multi-port register file with write-first bypass plus a
// per-register pending-write scoreboard that gates issue on RAW/WAW hazards.
module toy_operand_unit #(
    parameter int DW       = 32,
    parameter int AW       = 5,
    parameter int NRD      = 2,
    parameter int CW       = 2,
    parameter int ZERO_EN  = 0,
    parameter int ZERO_REG = 31
) (
    input  logic               CLK,
    input  logic               RSTN,
    toy_operand_unit_if.slave  bus
);
    localparam int            NREG = 1 << AW;
    localparam logic [CW-1:0] CMAX = '1;
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [DW-1:0]            mem_q [NREG];
    logic [CW-1:0]            cnt_q [NREG];
    logic [CW-1:0]            cnt_d [NREG];
    logic                     err_q, err_d;
    logic [NRD-1:0][DW-1:0]   rd_w;
    logic [NRD-1:0]           src_haz;
    logic                     dst_haz, issue_fire, busy;

    function automatic logic is_zero(input logic [AW-1:0] a);
        return (ZERO_EN != 0) && (a == AW'(ZERO_REG));
    endfunction

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        logic [AW-1:0] ra;
        logic [CW-1:0] c;
        logic          wr_hit;
        assign ra     = bus.RA[i*AW +: AW];
        assign c      = cnt_q[ra];
        assign wr_hit = bus.WEN && (bus.WA == ra);
        assign rd_w[i] = is_zero(ra) ? '0 : (wr_hit ? bus.DI : mem_q[ra]);
        // A writeback landing this cycle retires one pending write; if it was the last, bypass instead of stalling.
        assign src_haz[i] = bus.SRC_EN[i] && (c != '0) && !(wr_hit && c == ONE);
    end

    assign bus.RD      = rd_w;
    assign dst_haz     = bus.ISSUE_WEN && !is_zero(bus.ISSUE_WA) && (cnt_q[bus.ISSUE_WA] == CMAX);
    assign bus.ISSUE_READY = (src_haz == '0) && !dst_haz;
    assign issue_fire  = bus.ISSUE_VALID && bus.ISSUE_READY;
    assign bus.ERR     = err_q;
    assign bus.BUSY    = busy;

    always_comb begin
        err_d = err_q;
        busy  = 1'b0;
        for (int r = 0; r < NREG; r++) begin
            cnt_d[r] = cnt_q[r];
            busy     = busy | (cnt_q[r] != '0);
            if (!is_zero(AW'(r))) begin
                if (bus.WEN && bus.WA == AW'(r)) begin
                    if (cnt_q[r] == '0) err_d = 1'b1;
                    if (cnt_d[r] != '0) cnt_d[r] = cnt_d[r] - ONE;
                end
                if (bus.KILL_VALID && bus.KILL_WA == AW'(r)) begin
                    if (cnt_q[r] == '0) err_d = 1'b1;
                    if (cnt_d[r] != '0) cnt_d[r] = cnt_d[r] - ONE;
                end
                // Increment after decrements: issue is only accepted below saturation, so no wrap.
                if (issue_fire && bus.ISSUE_WEN && bus.ISSUE_WA == AW'(r))
                    cnt_d[r] = cnt_d[r] + ONE;
            end
        end
    end

    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            err_q <= 1'b0;
            for (int r = 0; r < NREG; r++) begin
                cnt_q[r] <= '0;
                mem_q[r] <= '0;
            end
        end else begin
            err_q <= err_d;
            for (int r = 0; r < NREG; r++) cnt_q[r] <= cnt_d[r];
            if (bus.WEN && !is_zero(bus.WA)) mem_q[bus.WA] <= bus.DI;
        end
    end
endmodule

// File: tb/tb_toy_operand_unit.sv
// Table-driven bench for toy_operand_unit: one instance with ZERO_EN=0, one with ZERO_EN=1.
module tb_toy_operand_unit;
    logic CLK = 1'b0;
    logic RSTN = 1'b1;
    always #5 CLK = ~CLK;

    toy_operand_unit_if #(.DW(32), .AW(5), .NRD(2)) b0 ();
    toy_operand_unit_if #(.DW(32), .AW(5), .NRD(2)) b1 ();

    toy_operand_unit #(.DW(32), .AW(5), .NRD(2), .CW(2), .ZERO_EN(0), .ZERO_REG(31))
        u0 (.CLK(CLK), .RSTN(RSTN), .bus(b0));
    toy_operand_unit #(.DW(32), .AW(5), .NRD(2), .CW(2), .ZERO_EN(1), .ZERO_REG(31))
        u1 (.CLK(CLK), .RSTN(RSTN), .bus(b1));

    typedef struct {
        bit          rst;   // async reset pulse before driving
        bit          z;     // compare the ZERO_EN=1 instance
        logic [4:0]  ra0, ra1;
        logic [1:0]  src;
        logic        iv, iwen;
        logic [4:0]  iwa;
        logic        wen;
        logic [4:0]  wa;
        logic [31:0] di;
        logic        kv;
        logic [4:0]  kwa;
        logic [31:0] e_rd0, e_rd1;
        logic        e_rdy, e_busy;
        int          e_err; // 2 = not checked
    } vec_t;

    vec_t tv[$];
    vec_t sb[$];
    int   n_run  = 0;
    int   n_fail = 0;

    function automatic vec_t V(bit rst, bit z, int ra0, int ra1, int src, int iv, int iwen, int iwa,
                               int wen, int wa, logic [31:0] di, int kv, int kwa,
                               logic [31:0] rd0, logic [31:0] rd1, int rdy, int busy, int err);
        vec_t t;
        t.rst = rst; t.z = z; t.ra0 = 5'(ra0); t.ra1 = 5'(ra1); t.src = 2'(src);
        t.iv = 1'(iv); t.iwen = 1'(iwen); t.iwa = 5'(iwa);
        t.wen = 1'(wen); t.wa = 5'(wa); t.di = di; t.kv = 1'(kv); t.kwa = 5'(kwa);
        t.e_rd0 = rd0; t.e_rd1 = rd1; t.e_rdy = 1'(rdy); t.e_busy = 1'(busy); t.e_err = err;
        return t;
    endfunction

    task automatic drive(input vec_t v);
        b0.RA = {v.ra1, v.ra0}; b0.SRC_EN = v.src;
        b0.ISSUE_VALID = v.iv; b0.ISSUE_WEN = v.iwen; b0.ISSUE_WA = v.iwa;
        b0.WEN = v.wen; b0.WA = v.wa; b0.DI = v.di; b0.KILL_VALID = v.kv; b0.KILL_WA = v.kwa;
        b1.RA = {v.ra1, v.ra0}; b1.SRC_EN = v.src;
        b1.ISSUE_VALID = v.iv; b1.ISSUE_WEN = v.iwen; b1.ISSUE_WA = v.iwa;
        b1.WEN = v.wen; b1.WA = v.wa; b1.DI = v.di; b1.KILL_VALID = v.kv; b1.KILL_WA = v.kwa;
    endtask

    task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s vec %0d: got %h want %h", name, idx, act, exp);
        end
    endtask

    task automatic check(input vec_t e, input int idx);
        logic [63:0] rd;
        logic        rdy, busy, err;
        rd   = e.z ? b1.RD : b0.RD;
        rdy  = e.z ? b1.ISSUE_READY : b0.ISSUE_READY;
        busy = e.z ? b1.BUSY : b0.BUSY;
        err  = e.z ? b1.ERR : b0.ERR;
        chk("rd0", idx, rd[31:0], e.e_rd0);
        chk("rd1", idx, rd[63:32], e.e_rd1);
        chk("ready", idx, 32'(rdy), 32'(e.e_rdy));
        chk("busy", idx, 32'(busy), 32'(e.e_busy));
        if (e.e_err != 2) chk("err", idx, 32'(err), 32'(e.e_err));
    endtask

    initial begin
        vec_t e;
        drive(V(0,0, 5,3,0, 0,0,0, 0,0,0, 0,0, 0,0,1,0,0));
        #2 RSTN = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        check(V(0,0, 5,3,0, 0,0,0, 0,0,0, 0,0, 0,0,1,0,0), -1);
        RSTN = 1'b1;

        //        rst z ra0 ra1 src iv iwen iwa wen wa di            kv kwa rd0           rd1           rdy busy err
        // bypass, then reset clears array and ERR
        tv.push_back(V(0,0, 5,3,0,  0,0,0,  0,0,0,             0,0, 0,            0,            1,0,0));
        tv.push_back(V(0,0, 7,3,0,  0,0,0,  1,7,32'hDEADBEEF,  0,0, 32'hDEADBEEF, 0,            1,0,0));
        tv.push_back(V(0,0, 7,7,0,  0,0,0,  0,0,0,             0,0, 32'hDEADBEEF, 32'hDEADBEEF, 1,0,1));
        tv.push_back(V(1,0, 7,5,0,  0,0,0,  0,0,0,             0,0, 0,            0,            1,0,0));
        // RAW stall on port 0, released by same-cycle writeback
        tv.push_back(V(0,0, 4,0,1,  1,1,4,  0,0,0,             0,0, 0,    0, 1,0,0));
        tv.push_back(V(0,0, 4,0,1,  0,0,0,  0,0,0,             0,0, 0,    0, 0,1,0));
        tv.push_back(V(0,0, 4,0,1,  0,0,0,  1,4,32'h12,        0,0, 32'h12,0,1,1,0));
        tv.push_back(V(0,0, 4,4,3,  0,0,0,  0,0,0,             0,0, 32'h12,32'h12,1,0,0));
        // RAW on port 1; SRC_EN=0 never stalls
        tv.push_back(V(0,0, 0,0,0,  1,1,6,  0,0,0,             0,0, 0,0,1,0,0));
        tv.push_back(V(0,0, 0,6,2,  0,0,0,  0,0,0,             0,0, 0,0,0,1,0));
        tv.push_back(V(0,0, 0,6,0,  0,0,0,  0,0,0,             0,0, 0,0,1,1,0));
        tv.push_back(V(0,0, 0,6,2,  0,0,0,  1,6,32'hA5A5,      0,0, 0,32'hA5A5,1,1,0));
        // saturation on r9 (CW=2 -> max 3 outstanding)
        tv.push_back(V(0,0, 9,0,0,  1,1,9,  0,0,0,             0,0, 0,0,1,0,0));
        tv.push_back(V(0,0, 9,0,0,  1,1,9,  0,0,0,             0,0, 0,0,1,1,0));
        tv.push_back(V(0,0, 9,0,0,  1,1,9,  0,0,0,             0,0, 0,0,1,1,0));
        tv.push_back(V(0,0, 9,0,0,  1,1,9,  0,0,0,             0,0, 0,0,0,1,0));
        tv.push_back(V(0,0, 9,0,0,  1,1,9,  1,9,32'h99,        0,0, 32'h99,0,0,1,0));
        tv.push_back(V(0,0, 9,0,0,  1,1,9,  1,9,32'h9A,        0,0, 32'h9A,0,1,1,0));
        tv.push_back(V(0,0, 9,0,0,  1,1,9,  0,0,0,             0,0, 32'h9A,0,1,1,0));
        tv.push_back(V(0,0, 9,0,0,  1,1,9,  0,0,0,             0,0, 32'h9A,0,0,1,0));
        tv.push_back(V(0,0, 9,0,0,  1,0,9,  0,0,0,             0,0, 32'h9A,0,1,1,0));
        // eff_cnt: writeback only bypasses when it retires the last pending write
        tv.push_back(V(0,0, 9,0,1,  0,0,0,  1,9,32'h1,         0,0, 32'h1,0,0,1,0));
        tv.push_back(V(0,0, 9,0,0,  0,0,0,  1,9,32'h2,         0,0, 32'h2,0,1,1,0));
        tv.push_back(V(0,0, 9,0,1,  0,0,0,  1,9,32'h3,         0,0, 32'h3,0,1,1,0));
        tv.push_back(V(0,0, 9,0,1,  0,0,0,  0,0,0,             0,0, 32'h3,0,1,0,0));
        // kill releases, then stray writeback raises sticky ERR
        tv.push_back(V(0,0, 0,0,0,  1,1,2,  0,0,0,             0,0, 0,0,1,0,0));
        tv.push_back(V(0,0, 0,0,0,  0,0,0,  0,0,0,             1,2, 0,0,1,1,0));
        tv.push_back(V(0,0, 2,0,0,  0,0,0,  0,0,0,             0,0, 0,0,1,0,0));
        tv.push_back(V(0,0, 2,0,0,  0,0,0,  1,2,32'h2222,      0,0, 32'h2222,0,1,0,0));
        tv.push_back(V(0,0, 2,0,0,  0,0,0,  0,0,0,             0,0, 32'h2222,0,1,0,1));
        // writeback+kill on same reg: -2, and clamp at 0
        tv.push_back(V(1,0, 2,0,0,  1,1,3,  0,0,0,             0,0, 0,0,1,0,0));
        tv.push_back(V(0,0, 0,0,0,  1,1,3,  0,0,0,             0,0, 0,0,1,1,0));
        tv.push_back(V(0,0, 3,0,0,  0,0,0,  1,3,32'h33,        1,3, 32'h33,0,1,1,0));
        tv.push_back(V(0,0, 3,0,0,  0,0,0,  0,0,0,             0,0, 32'h33,0,1,0,0));
        tv.push_back(V(0,0, 3,0,0,  1,1,3,  0,0,0,             0,0, 32'h33,0,1,0,0));
        tv.push_back(V(0,0, 3,0,0,  0,0,0,  1,3,32'h44,        1,3, 32'h44,0,1,1,0));
        tv.push_back(V(0,0, 3,0,1,  0,0,0,  0,0,0,             0,0, 32'h44,0,1,0,2));
        // writeback to idle reg with SRC_EN must not stall (no underflow)
        tv.push_back(V(1,0, 3,0,0,  0,0,0,  0,0,0,             0,0, 0,0,1,0,0));
        tv.push_back(V(0,0, 8,0,1,  0,0,0,  1,8,32'h8,         0,0, 32'h8,0,1,0,0));
        tv.push_back(V(0,0, 8,0,0,  0,0,0,  0,0,0,             0,0, 32'h8,0,1,0,1));
        // ZERO_EN=1 instance, hardwired r31
        tv.push_back(V(1,1, 31,0,0,  0,0,0,  1,31,32'h55,      0,0,  0,0,1,0,0));
        tv.push_back(V(0,1, 31,31,0, 0,0,0,  0,0,0,            0,0,  0,0,1,0,0));
        tv.push_back(V(0,1, 0,0,0,   1,1,31, 0,0,0,            0,0,  0,0,1,0,0));
        tv.push_back(V(0,1, 31,0,1,  1,1,31, 0,0,0,            0,0,  0,0,1,0,0));
        tv.push_back(V(0,1, 0,0,0,   0,0,0,  0,0,0,            1,31, 0,0,1,0,0));
        tv.push_back(V(0,1, 31,31,3, 0,0,0,  0,0,0,            0,0,  0,0,1,0,0));
        tv.push_back(V(0,1, 0,0,0,   1,1,5,  0,0,0,            0,0,  0,0,1,0,0));
        tv.push_back(V(0,1, 5,0,1,   0,0,0,  0,0,0,            0,0,  0,0,0,1,0));
        tv.push_back(V(0,1, 5,0,1,   0,0,0,  1,5,32'h5,        0,0,  32'h5,0,1,1,0));
        tv.push_back(V(0,1, 5,0,0,   0,0,0,  0,0,0,            0,0,  32'h5,0,1,0,0));

        foreach (tv[i]) begin
            @(posedge CLK);
            #1;
            if (tv[i].rst) begin
                RSTN = 1'b0;
                #1 RSTN = 1'b1;
            end
            drive(tv[i]);
            sb.push_back(tv[i]);
            @(negedge CLK);
            e = sb.pop_front();
            check(e, i);
        end

        // asynchronous reset in the middle of a cycle drops pending state at once
        @(posedge CLK); #1;
        drive(V(0,1, 0,0,0, 1,1,10, 0,0,0, 0,0, 0,0,1,0,0));
        @(posedge CLK); #1;
        drive(V(0,1, 10,0,1, 0,0,0, 0,0,0, 0,0, 0,0,0,1,0));
        @(negedge CLK);
        chk("midrst_busy_before", 100, 32'(b1.BUSY), 32'd1);
        chk("midrst_ready_before", 100, 32'(b1.ISSUE_READY), 32'd0);
        RSTN = 1'b0;
        #1;
        chk("midrst_busy_after", 101, 32'(b1.BUSY), 32'd0);
        chk("midrst_ready_after", 101, 32'(b1.ISSUE_READY), 32'd1);
        chk("midrst_err_after", 101, 32'(b1.ERR), 32'd0);
        RSTN = 1'b1;

        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end
endmodule
